// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the serial adder sequencer.
package serial_add_pkg;

    localparam int unsigned N_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_LOAD,
        ST_SHIFT,
        ST_CAPT,
        ST_DONE
    } state_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Bit-cycle counter for the SHIFT phase; flags the final bit and holds there.
module bit_counter #(
    parameter int unsigned W    = 2,
    parameter int unsigned LAST = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign last = (cnt_q == W'(LAST));

    // Saturate on the last bit so the count never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !last) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Sequencer for the serial_adder core: accepts an operand pair, runs N
// shift cycles, captures the core's sum and returns it over valid/ready.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic [N-1:0] adder_a,
    output logic [N-1:0] adder_b,
    output logic         adder_clr,
    output logic         adder_ld,
    output logic         adder_en,
    input  logic [N-1:0] adder_sum,
    input  logic         adder_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_cout
);

    localparam int unsigned CW = cnt_w(N);

    state_t       state_q, state_d;
    logic [N-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic         cout_q, cout_d;
    logic         in_ready_q, in_ready_d;
    logic         clr_q, clr_d, ld_q, ld_d, en_q, en_d, ov_q, ov_d;
    logic         cnt_last_c;

    bit_counter #(
        .W    (CW),
        .LAST (N - 1)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == ST_CLR),
        .en   (state_q == ST_SHIFT),
        .last (cnt_last_c)
    );

    // Next state and data; control outputs are a registered decode of the next state.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    state_d = ST_CLR;
                end
            end
            ST_CLR:   state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_last_c) state_d = ST_CAPT;
            ST_CAPT: begin
                sum_d   = adder_sum;
                cout_d  = adder_cout;
                state_d = ST_DONE;
            end
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
        clr_d      = (state_d == ST_CLR);
        ld_d       = (state_d == ST_LOAD);
        en_d       = (state_d == ST_SHIFT);
        ov_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            in_ready_q <= 1'b1;
            clr_q      <= 1'b0;
            ld_q       <= 1'b0;
            en_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            in_ready_q <= in_ready_d;
            clr_q      <= clr_d;
            ld_q       <= ld_d;
            en_q       <= en_d;
            ov_q       <= ov_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign adder_a   = a_q;
    assign adder_b   = b_q;
    assign adder_clr = clr_q;
    assign adder_ld  = ld_q;
    assign adder_en  = en_q;
    assign out_valid = ov_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl with a behavioural LSB-first serial adder core
// and an arithmetic a+b reference.
module tb_serial_adder_ctrl;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_a = '0;
    logic [N-1:0] in_b = '0;
    logic [N-1:0] adder_a, adder_b, adder_sum, out_sum;
    logic         adder_clr, adder_ld, adder_en, adder_cout;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_cout;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_clr  (adder_clr),
        .adder_ld   (adder_ld),
        .adder_en   (adder_en),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout)
    );

    // Serial adder core: one bit per enabled cycle, sum shifted in from the MSB side.
    logic [N-1:0] ca, cb, cs;
    logic         cc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst || adder_clr) begin
            ca <= '0; cb <= '0; cs <= '0; cc <= 1'b0;
        end else if (adder_ld) begin
            ca <= adder_a; cb <= adder_b; cs <= '0; cc <= 1'b0;
        end else if (adder_en) begin
            cs <= {ca[0] ^ cb[0] ^ cc, cs[N-1:1]};
            cc <= (ca[0] & cb[0]) | (cc & (ca[0] ^ cb[0]));
            ca <= ca >> 1;
            cb <= cb >> 1;
        end
    end
    assign adder_sum  = cs;
    assign adder_cout = cc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
        check({tag, "_clr"}, 32'(adder_clr), 32'(0));
        check({tag, "_ld"}, 32'(adder_ld), 32'(0));
        check({tag, "_en"}, 32'(adder_en), 32'(0));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        check({tag, "_adder_a"}, 32'(adder_a), 32'(0));
        check({tag, "_adder_b"}, 32'(adder_b), 32'(0));
        check({tag, "_out_sum"}, 32'(out_sum), 32'(0));
        check({tag, "_out_cout"}, 32'(out_cout), 32'(0));
    endtask

    // One job; junk=1 keeps in_valid high with pair (3,4) while busy.
    task automatic run_job(input logic [N-1:0] a, input logic [N-1:0] b,
                           input int hold, input bit junk);
        logic [N:0] exp;
        int k, en_cnt, clr_cnt, ld_cnt, rdy_cnt;
        bit got;
        exp = {1'b0, a} + {1'b0, b};
        en_cnt = 0; clr_cnt = 0; ld_cnt = 0; rdy_cnt = 0; got = 1'b0;
        check("ready_before_accept", 32'(in_ready), 32'(1));
        in_a = a; in_b = b; in_valid = 1'b1;
        tick();
        check("adder_a_latched", 32'(adder_a), 32'(a));
        check("adder_b_latched", 32'(adder_b), 32'(b));
        for (k = 1; k <= int'(N) + 20; k++) begin
            if (junk) begin
                in_a = N'(3); in_b = N'(4); in_valid = 1'b1;
            end else begin
                in_a = N'($urandom); in_b = N'($urandom); in_valid = 1'($urandom);
            end
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            en_cnt  += int'(adder_en);
            clr_cnt += int'(adder_clr);
            ld_cnt  += int'(adder_ld);
            rdy_cnt += int'(in_ready);
            tick();
        end
        if (!junk) in_valid = 1'b0;
        check("valid_timeout", 32'(got), 32'(1));
        check("latency", 32'(k), 32'(N + 4));
        check("en_cycles", 32'(en_cnt), 32'(N));
        check("clr_cycles", 32'(clr_cnt), 32'(1));
        check("ld_cycles", 32'(ld_cnt), 32'(1));
        check("ready_while_busy", 32'(rdy_cnt), 32'(0));
        check("sum", 32'(out_sum), 32'(exp[N-1:0]));
        check("cout", 32'(out_cout), 32'(exp[N]));
        check("operand_held", 32'(adder_a), 32'(a));
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            tick();
            check("hold_valid", 32'(out_valid), 32'(1));
            check("hold_sum", 32'(out_sum), 32'(exp[N-1:0]));
            check("hold_cout", 32'(out_cout), 32'(exp[N]));
            check("hold_ready", 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'(0));
        check("post_idle", 32'(in_ready), 32'(1));
    endtask

    initial begin
        bit         vseen;
        int         acc_cnt, res_cnt, last_acc;
        logic [N:0] exp_q[$];
        logic [N:0] e;

        tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();
        check_reset_vals("idle");

        run_job(N'(5), N'(6), 0, 1'b0);
        run_job(N'(9), N'(8), 0, 1'b0);
        run_job(N'(15), N'(15), 10, 1'b0);
        run_job(N'($urandom), N'($urandom), 0, 1'b1);
        run_job(N'(3), N'(4), 0, 1'b0);

        // Reset during the second SHIFT cycle.
        in_a = N'($urandom); in_b = N'($urandom); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_shift_en", 32'(adder_en), 32'(1));
        rst = 1'b1;
        #1;
        check_reset_vals("async_reset");
        tick();
        rst = 1'b0;
        vseen = 1'b0;
        for (int i = 0; i < int'(N) + 8; i++) begin
            vseen |= out_valid;
            tick();
        end
        check("no_valid_after_reset", 32'(vseen), 32'(0));
        run_job(N'(2), N'(2), 0, 1'b0);

        // Back-to-back jobs with both handshakes held high.
        acc_cnt = 0; res_cnt = 0; last_acc = 0;
        in_a = N'($urandom); in_b = N'($urandom);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4 * (int'(N) + 5); i++) begin
            bit acc;
            acc = in_ready && in_valid;
            if (acc) begin
                exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
                if (acc_cnt > 0) check("b2b_spacing", 32'(i - last_acc), 32'(N + 5));
                last_acc = i;
                acc_cnt++;
            end
            if (out_valid) begin
                check("b2b_queue_nonempty", 32'(exp_q.size() > 0), 32'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("b2b_sum", 32'(out_sum), 32'(e[N-1:0]));
                    check("b2b_cout", 32'(out_cout), 32'(e[N]));
                end
                res_cnt++;
            end
            tick();
            if (acc) begin
                in_a = N'($urandom); in_b = N'($urandom);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_accepts", 32'(acc_cnt), 32'(4));
        check("b2b_results", 32'(res_cnt), 32'(4));
        tick();

        for (int j = 0; j < 4; j++) begin
            run_job(N'($urandom), N'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
